// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - four-button synchronizer, debouncer and one-hot press pulse generator
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] control,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [3:0]       rise;
    logic [3:0]       winner;
    logic [CNT_W-1:0] cnt [4];

    // Two-flop synchronizer; only sync2 is trusted downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced levels for press-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;

    // Highest-index press wins; simultaneous lower presses are dropped.
    always_comb begin
        winner = 4'b0000;
        if (rise[3]) begin
            winner = 4'b1000;
        end else if (rise[2]) begin
            winner = 4'b0100;
        end else if (rise[1]) begin
            winner = 4'b0010;
        end else if (rise[0]) begin
            winner = 4'b0001;
        end
    end

    // Register the one-hot result so each accepted press yields exactly one cycle of control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            control <= '0;
        end else begin
            control <= winner;
        end
    end

    assign held = stable;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench for button_conditioner against a window-rule model
module tb_button_conditioner;

    localparam int D = 4;
    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] control;
    logic [3:0] held;

    int n_vec  = 0;
    int n_bad  = 0;
    int pulses = 0;

    // hist[k] = btn_raw sampled k+1 edges ago (hist[0] is the most recent sample)
    logic [3:0] hist [D+1];
    logic [3:0] m_stable;
    logic [3:0] m_stable_d;
    logic [3:0] m_ctrl;

    int dur [4];

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .control(control),
        .held   (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pick_highest(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    // A button's debounced level flips once the synchronized level has disagreed with it
    // on D consecutive edges; the synchronized level at an edge is the raw sample from two edges earlier.
    task automatic step(input string tag);
        logic [3:0] nxt;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k <= D; k++) hist[k] = 4'b0000;
            m_stable   = 4'b0000;
            m_stable_d = 4'b0000;
            m_ctrl     = 4'b0000;
        end else begin
            nxt = m_stable;
            for (int b = 0; b < 4; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 1; k <= D; k++) begin
                    if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) nxt[b] = ~m_stable[b];
            end
            m_ctrl     = pick_highest(m_stable & ~m_stable_d);
            m_stable_d = m_stable;
            m_stable   = nxt;
            for (int k = D; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn_raw;
        end
        @(negedge clk);
        check({tag, ".control"}, control, m_ctrl);
        check({tag, ".held"}, held, m_stable);
        check({tag, ".onehot"}, 4'($countones(control) <= 1), 4'd1);
        if (control != 4'b0000) pulses++;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 4'b1111;
        run("reset", 4);
        rst    = 1'b0;
        pulses = 0;
        run("reset_release", 10);
        check("reset_release.pulses", 4'(pulses), 4'd1);

        btn_raw = 4'b0000;
        run("idle", 10);
        pulses  = 0;
        btn_raw = 4'b1000;
        run("clean_press", 20);
        check("clean_press.pulses", 4'(pulses), 4'd1);

        btn_raw = 4'b0000;
        run("idle", 10);
        pulses = 0;
        for (int t = 0; t < 4; t++) begin
            btn_raw[2] = ~t[0];
            run("bounce", 2);
        end
        check("bounce.no_early_pulse", 4'(pulses), 4'd0);
        btn_raw[2] = 1'b1;
        run("bounce_settle", 12);
        check("bounce.pulses", 4'(pulses), 4'd1);

        btn_raw = 4'b0000;
        run("idle", 10);
        pulses  = 0;
        btn_raw = 4'b0101;
        run("simultaneous", 12);
        check("simultaneous.pulses", 4'(pulses), 4'd1);
        check("simultaneous.held", held, 4'b0101);

        btn_raw = 4'b1000;
        run("hold", 12);
        pulses  = 0;
        btn_raw = 4'b0000;
        run("release", 10);
        check("release.pulses", 4'(pulses), 4'd0);
        check("release.held", held, 4'b0000);

        run("idle", 6);
        pulses  = 0;
        btn_raw = 4'b0010;
        run("mid_debounce", 4);
        rst = 1'b1;
        run("mid_reset", 2);
        rst = 1'b0;
        run("mid_release", 12);
        check("mid_reset.pulses", 4'(pulses), 4'd1);

        for (int b = 0; b < 4; b++) dur[b] = $urandom_range(1, 8);
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++) begin
                dur[b]--;
                if (dur[b] <= 0) begin
                    btn_raw[b] = ~btn_raw[b];
                    dur[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(3, 12);
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step("random");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
